// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants, types and decode helpers for the MEM-stage
// data memory controller (dmem_wait_ctrl) and its RAM (dmem_lane_ram).
//   - funct3 encodings for loads/stores
//   - FSM state enum
//   - latched request struct
//   - access_fault(): illegal-funct3 / misalignment check
package dmem_pkg;

    localparam int WAIT_CW = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // Stores only know b/h/w; loads add the unsigned b/h forms. funct3[1:0]
    // encodes the access size for every legal encoding, so the alignment
    // check can key off it directly.
    function automatic logic access_fault(input logic       we,
                                          input logic [2:0] f3,
                                          input logic [1:0] a);
        logic illegal;
        logic misal;
        if (we)
            illegal = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        else
            illegal = !(f3 == F3_B || f3 == F3_H || f3 == F3_W ||
                        f3 == F3_BU || f3 == F3_HU);
        misal = ((f3[1:0] == 2'b01) && a[0]) ||
                ((f3[1:0] == 2'b10) && (a != 2'b00));
        return illegal | misal;
    endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// dmem_lane_ram: DEPTH x 32 data array, little-endian byte lanes.
//   clk     in   clock
//   we      in   write strobe; bytes selected by be are written
//   be      in   [3:0] byte enables, bit i -> wdata[8i+7:8i]
//   addr    in   [AW-1:0] word index (shared by read and write)
//   wdata   in   [31:0] lane-replicated write data
//   re      in   read strobe; rdata_q captures the word on this edge
//   rdata_q out  [31:0] registered read data (old contents on same-edge write)
// Contents are intentionally not reset.
module dmem_lane_ram #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata_q
);

    logic [3:0][7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][i] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata_q <= mem[addr];
    end

endmodule

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: byte-addressed RISC-V data memory with configurable wait
// states and a valid/ready request / one-cycle response handshake.
//   clk, rst      clock; asynchronous active-high reset
//   req_valid     request present (sampled only while req_ready=1)
//   req_we        1 = store, 0 = load
//   req_funct3    RISC-V funct3 (size / signedness)
//   req_addr      byte address; word index addr[AW+1:2], wraps modulo DEPTH
//   req_wdata     right-aligned store data
//   req_ready     high in IDLE only
//   resp_valid    one-cycle response strobe
//   resp_rdata    extended load data; 0 for stores, faults and outside resp
//   resp_fault    misaligned / illegal access, qualified by resp_valid
module dmem_wait_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);

    localparam int AW      = $clog2(DEPTH);
    localparam bit NO_WAIT = (WAIT == 0);

    state_t               state_q, state_d;
    logic [WAIT_CW-1:0]   cnt_q, cnt_d;
    dmem_req_t            req_q, req_d;
    logic                 fault_q, fault_d;

    // In IDLE the commit (WAIT=0) uses the live request; otherwise the
    // latched copy drives decode.
    dmem_req_t            req_in, cur;
    logic                 cur_fault;
    logic                 commit;
    logic [3:0]           be;
    logic [31:0]          wdata_lane;
    logic [31:0]          ram_rdata;
    logic                 unused_addr_bits;

    assign req_in = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
    assign cur       = (state_q == S_IDLE) ? req_in : req_q;
    assign cur_fault = access_fault(cur.we, cur.funct3, cur.addr[1:0]);
    assign unused_addr_bits = ^cur.addr[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        fault_d = fault_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    req_d   = req_in;
                    fault_d = cur_fault;
                    if (cur_fault) begin
                        state_d = S_RESP;
                    end else if (NO_WAIT) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_CW'(WAIT);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == WAIT_CW'(1)) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                fault_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    // Lane steering: replicate the right-aligned data across the word and
    // let the byte enables pick the destination lanes.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = cur.wdata;
        case (cur.funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << cur.addr[1:0];
                wdata_lane = {4{cur.wdata[7:0]}};
            end
            2'b01: begin
                be         = cur.addr[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{cur.wdata[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // rst gating covers a reset that lands on the commit edge itself.
    dmem_lane_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we      (commit & cur.we & ~rst),
        .be      (be),
        .addr    (cur.addr[AW+1:2]),
        .wdata   (wdata_lane),
        .re      (commit & ~cur.we),
        .rdata_q (ram_rdata)
    );

    // Response fields come straight from flops (state, latched request,
    // RAM output register); they are forced to 0 outside RESP.
    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_shift = ram_rdata >> {req_q.addr[1:0], 3'b000};
    assign rd_byte  = rd_shift[7:0];
    assign rd_half  = req_q.addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        resp_rdata = '0;
        if (state_q == S_RESP && !fault_q && !req_q.we) begin
            case (req_q.funct3)
                F3_B:    resp_rdata = {{24{rd_byte[7]}}, rd_byte};
                F3_BU:   resp_rdata = {24'b0, rd_byte};
                F3_H:    resp_rdata = {{16{rd_half[15]}}, rd_half};
                F3_HU:   resp_rdata = {16'b0, rd_half};
                F3_W:    resp_rdata = ram_rdata;
                default: resp_rdata = '0;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_fault = (state_q == S_RESP) & fault_q;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
module tb_dmem_wait_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        sel;

    logic        rdy0, rdy1, rv0, rv1, rf0, rf1;
    logic [31:0] rd0, rd1;
    logic        ready, resp_valid, resp_fault;
    logic [31:0] resp_rdata;

    always #5 clk = ~clk;

    dmem_wait_ctrl #(.DEPTH(256), .WAIT(2)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rdy0), .resp_valid(rv0), .resp_rdata(rd0), .resp_fault(rf0));

    dmem_wait_ctrl #(.DEPTH(256), .WAIT(0)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rdy1), .resp_valid(rv1), .resp_rdata(rd1), .resp_fault(rf1));

    assign ready      = sel ? rdy1 : rdy0;
    assign resp_valid = sel ? rv1  : rv0;
    assign resp_rdata = sel ? rd1  : rd0;
    assign resp_fault = sel ? rf1  : rf0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   ncmp = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction; expected response is queued at drive time
    // and popped when resp_valid is seen.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic ef, input int el);
        exp_t e;
        int   lat;
        bit   got;
        e.rdata = er; e.fault = ef; e.lat = el[7:0];
        sb.push_back(e);
        @(negedge clk);
        chk({tag, "_ready"}, {31'b0, ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        lat = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (resp_valid === 1'b1) got = 1'b1;
        end
        chk({tag, "_seen"}, {31'b0, got}, 32'd1);
        e = sb.pop_front();
        if (got) begin
            chk({tag, "_rdata"}, resp_rdata, e.rdata);
            chk({tag, "_fault"}, {31'b0, resp_fault}, {31'b0, e.fault});
            chk({tag, "_lat"}, lat, {24'b0, e.lat});
        end
        @(negedge clk);
        chk({tag, "_post_valid"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "_post_rdata"}, resp_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_fault", {31'b0, resp_fault}, 32'd0);
        rst = 1'b0;

        // WAIT=2 instance
        do_req("sw10",  1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        0, 3);
        do_req("lw10",  0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 0, 3);
        do_req("sb13",  1, F3_B,  32'h13, 32'h00000080, 32'h0,        0, 3);
        do_req("lb13",  0, F3_B,  32'h13, 32'h0,        32'hFFFFFF80, 0, 3);
        do_req("lbu13", 0, F3_BU, 32'h13, 32'h0,        32'h00000080, 0, 3);
        do_req("lw10b", 0, F3_W,  32'h10, 32'h0,        32'h80ADBEEF, 0, 3);
        do_req("sw20",  1, F3_W,  32'h20, 32'hCAFEF00D, 32'h0,        0, 3);
        do_req("sh22",  1, F3_H,  32'h22, 32'hFFFF1234, 32'h0,        0, 3);
        do_req("lhu22", 0, F3_HU, 32'h22, 32'h0,        32'h00001234, 0, 3);
        do_req("lw20",  0, F3_W,  32'h20, 32'h0,        32'h1234F00D, 0, 3);
        do_req("sh20",  1, F3_H,  32'h20, 32'h0000BEEF, 32'h0,        0, 3);
        do_req("lh20",  0, F3_H,  32'h20, 32'h0,        32'hFFFFBEEF, 0, 3);
        do_req("lh22",  0, F3_H,  32'h22, 32'h0,        32'h00001234, 0, 3);
        do_req("lb21",  0, F3_B,  32'h21, 32'h0,        32'hFFFFFFBE, 0, 3);

        // faults: 1-cycle latency, rdata 0, no array access
        do_req("f_lw11",  0, F3_W,   32'h11, 32'h0,        32'h0, 1, 1);
        do_req("f_sh21",  1, F3_H,   32'h21, 32'h0000FFFF, 32'h0, 1, 1);
        do_req("f_ld011", 0, 3'b011, 32'h20, 32'h0,        32'h0, 1, 1);
        do_req("f_st100", 1, 3'b100, 32'h20, 32'h00000000, 32'h0, 1, 1);
        do_req("f_sw22",  1, F3_W,   32'h22, 32'h00000000, 32'h0, 1, 1);
        do_req("lw20c",   0, F3_W,   32'h20, 32'h0,        32'h1234BEEF, 0, 3);

        // address wrap modulo DEPTH
        do_req("sw400", 1, F3_W, 32'h400, 32'hA5A5A5A5, 32'h0,        0, 3);
        do_req("lw000", 0, F3_W, 32'h000, 32'h0,        32'hA5A5A5A5, 0, 3);

        // reset mid-WAIT abandons the store
        do_req("sw30", 1, F3_W, 32'h30, 32'h5555AAAA, 32'h0, 0, 3);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
        req_addr = 32'h30; req_wdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'b0, ready}, 32'd1);
        chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("mid_rst_rdata", resp_rdata, 32'd0);
        chk("mid_rst_fault", {31'b0, resp_fault}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_req("lw30", 0, F3_W, 32'h30, 32'h0, 32'h5555AAAA, 0, 3);

        // WAIT=0 instance
        sel = 1'b1;
        do_req("w0_sw4", 1, F3_W,  32'h4, 32'h12345678, 32'h0,        0, 1);
        do_req("w0_lw4", 0, F3_W,  32'h4, 32'h0,        32'h12345678, 0, 1);
        do_req("w0_lhu6",0, F3_HU, 32'h6, 32'h0,        32'h00001234, 0, 1);
        do_req("w0_f",   0, F3_H,  32'h5, 32'h0,        32'h0,        1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
